writeback_commit_unit: RTL and testbench
========================================

// Module: writeback_commit_unit
// PURPOSE
//  Consumer end of the memory->writeback pipeline register. Takes the registered writeback-stage
//  bundle, aligns/extends load data, drives the register-file write port, retires instructions.
//  Holds a one-cycle WB->decode bypass register (covers regfile read-before-write) and a retire counter.
// PARAMETERS
//  DATA_WIDTH     32  datapath width (only 32 supported)
//  COUNTER_WIDTH  64  width of instret retire counter
// PORTS
//  clock                  in   1   rising-edge clock
//  reset                  in   1   synchronous, active-high
//  ALU_result_writeback   in   32  ALU result; loads: effective address, bits[1:0] = byte offset
//  load_data_writeback    in   32  raw aligned memory word
//  opwrite_writeback      in   1   instruction writes rd
//  opsel_writeback        in   1   1 = select load data, 0 = ALU result
//  opReg_writeback        in   5   destination register
//  instruction_writeback  in   32  instruction word (funct3 = [14:12], opcode = [6:0])
//  write_enable           out  1   regfile write strobe (combinational)
//  write_reg              out  5   regfile write address (combinational)
//  write_data             out  32  regfile write data (combinational)
//  bypass_valid           out  1   registered: previous-cycle write is visible on bypass_*
//  bypass_reg             out  5   registered rd of previous-cycle write
//  bypass_data            out  32  registered data of previous-cycle write
//  retire_valid           out  1   combinational: current WB instruction retires this cycle
//  instret                out  64  registered retire count
// BEHAVIOUR
//  - write_enable = !reset & opwrite_writeback & (opReg_writeback != 0); x0 writes suppressed.
//  - write_reg = opReg_writeback; write_data = opsel ? aligned_load : ALU_result_writeback.
//  - Load align (opcode 7'b0000011), off = ALU_result[1:0]:
//    LB/LBU(000/100): byte off, sign/zero-extend; LH/LHU(001/101): half at off[1], off[0] ignored;
//    LW(010): full word, off ignored; other funct3: full word unmodified.
//  - opsel=1 with non-load opcode: raw load_data_writeback passed through.
//  - retire_valid = !reset & (instruction_writeback != 32'h00000013); canonical NOP (bubble) never retires.
//  - instret += 1 on each clock with retire_valid; wraps to 0 from all-ones, no saturation.
//  - Bypass: each clock, bypass_valid<=write_enable; when write_enable, bypass_reg/data<=write_reg/data;
//    otherwise reg/data hold last value. Latency exactly 1 cycle, depth 1.
//  - Reset (any cycle, incl. mid-stream): bypass_valid=0, bypass_reg=0, bypass_data=0, instret=0;
//    write_enable=0, retire_valid=0 while reset high regardless of inputs.
//  - No stall/flush inputs: every clock consumes one bundle; bubbles arrive as NOP/opwrite=0.
// CONFIGURATION
//  COMMIT_TRACE_EN defined: adds registered outputs trace_valid(1), trace_instr(32), trace_rd(5),
//   trace_data(32), trace_cycle(64). trace_valid<=retire_valid; other fields captured on retire;
//   trace_rd/data = 0 when the retiring instruction does not write (or writes x0);
//   trace_cycle is free-running cycle count (reset 0) sampled at retire. All reset to 0.
//  Undefined: trace ports and cycle counter absent; all other behaviour identical.
// STRUCTURE
//  Shared package: NOP constant 32'h00000013, OPCODE_LOAD, funct3 encodings LB/LH/LW/LBU/LHU.
//  Sub-module: load_data_align (combinational: word, offset, funct3 -> extended 32-bit value).
//  Top holds bypass register, instret counter, optional trace registers.
// TESTING
//  LB, off=3, word 32'h80FF_1234 -> write_data 32'hFFFF_FF80; LBU same -> 32'h0000_0080.
//  LH off=2 word 32'h8001_7FFF -> 32'hFFFF_8001; LHU off=3 -> 32'h0000_8001 (off[0] ignored).
//  opwrite=1, rd=0, ALU 32'h5 -> write_enable 0, bypass_valid 0 next cycle, instret +1.
//  ADDI rd=7 ALU 32'h2A then NOP -> cycle+1: bypass_valid 1, reg 7, data 32'h2A; cycle+2: valid 0, data holds.
//  10 NOPs then 3 real instrs -> instret 3; preload near all-ones via force -> wraps to 0.
//  Assert reset mid-stream with opwrite=1 -> write_enable/retire_valid 0; bypass, instret (trace) cleared next edge.

Source files
------------

// File: rtl/writeback_commit_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_commit_unit_pkg
// Description : Shared constants for the writeback/commit stage.
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_commit_unit_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [6:0]  OPCODE_LOAD = 7'b0000011;

    localparam logic [2:0]  F3_LB  = 3'b000;
    localparam logic [2:0]  F3_LH  = 3'b001;
    localparam logic [2:0]  F3_LW  = 3'b010;
    localparam logic [2:0]  F3_LBU = 3'b100;
    localparam logic [2:0]  F3_LHU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/writeback_commit_unit_load_data_align.sv
`default_nettype none
// ============================================================================
// Module      : load_data_align
// Description : Selects the addressed byte/half of a load word and extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module load_data_align
    import writeback_commit_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] aligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[7:0];
        case (offset)
            2'd0: w_byte = word[7:0];
            2'd1: w_byte = word[15:8];
            2'd2: w_byte = word[23:16];
            2'd3: w_byte = word[31:24];
            default: w_byte = word[7:0];
        endcase
        // Halfwords are assumed naturally aligned; offset[0] is ignored.
        w_half = offset[1] ? word[31:16] : word[15:0];

        aligned = word;
        case (funct3)
            F3_LB:   aligned = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  aligned = {24'd0, w_byte};
            F3_LH:   aligned = {{16{w_half[15]}}, w_half};
            F3_LHU:  aligned = {16'd0, w_half};
            F3_LW:   aligned = word;
            default: aligned = word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/writeback_commit_unit.sv
`default_nettype none
// ============================================================================
// Module      : writeback_commit_unit
// Description : Writeback stage: load alignment, regfile write port, 1-deep
//               WB->decode bypass register and retire counter.
//               Optional trace outputs when COMMIT_TRACE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_commit_unit
    import writeback_commit_unit_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int COUNTER_WIDTH = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    ALU_result_writeback,
    input  logic [DATA_WIDTH-1:0]    load_data_writeback,
    input  logic                     opwrite_writeback,
    input  logic                     opsel_writeback,
    input  logic [4:0]               opReg_writeback,
    input  logic [31:0]              instruction_writeback,
    output logic                     write_enable,
    output logic [4:0]               write_reg,
    output logic [DATA_WIDTH-1:0]    write_data,
    output logic                     bypass_valid,
    output logic [4:0]               bypass_reg,
    output logic [DATA_WIDTH-1:0]    bypass_data,
    output logic                     retire_valid,
`ifdef COMMIT_TRACE_EN
    output logic                     trace_valid,
    output logic [31:0]              trace_instr,
    output logic [4:0]               trace_rd,
    output logic [DATA_WIDTH-1:0]    trace_data,
    output logic [COUNTER_WIDTH-1:0] trace_cycle,
`endif
    output logic [COUNTER_WIDTH-1:0] instret
);

    logic [DATA_WIDTH-1:0]    w_aligned;
    logic                     w_is_load;
    logic [DATA_WIDTH-1:0]    w_load_value;

    logic                     r_bypass_valid;
    logic [4:0]               r_bypass_reg;
    logic [DATA_WIDTH-1:0]    r_bypass_data;
    logic [COUNTER_WIDTH-1:0] r_instret;

    load_data_align u_align (
        .word    (load_data_writeback),
        .offset  (ALU_result_writeback[1:0]),
        .funct3  (instruction_writeback[14:12]),
        .aligned (w_aligned)
    );

    // Non-load instructions selecting load data get the raw word.
    assign w_is_load    = (instruction_writeback[6:0] == OPCODE_LOAD);
    assign w_load_value = w_is_load ? w_aligned : load_data_writeback;

    assign write_enable = !reset && opwrite_writeback && (opReg_writeback != 5'd0);
    assign write_reg    = opReg_writeback;
    assign write_data   = opsel_writeback ? w_load_value : ALU_result_writeback;
    assign retire_valid = !reset && (instruction_writeback != NOP_INSTR);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bypass_valid <= 1'b0;
            r_bypass_reg   <= 5'd0;
            r_bypass_data  <= '0;
            r_instret      <= '0;
        end else begin
            r_bypass_valid <= write_enable;
            if (write_enable) begin
                r_bypass_reg  <= write_reg;
                r_bypass_data <= write_data;
            end
            if (retire_valid)
                r_instret <= r_instret + 1'b1;
        end
    end

    assign bypass_valid = r_bypass_valid;
    assign bypass_reg   = r_bypass_reg;
    assign bypass_data  = r_bypass_data;
    assign instret      = r_instret;

`ifdef COMMIT_TRACE_EN
    logic [COUNTER_WIDTH-1:0] r_cycle;
    logic                     r_trace_valid;
    logic [31:0]              r_trace_instr;
    logic [4:0]               r_trace_rd;
    logic [DATA_WIDTH-1:0]    r_trace_data;
    logic [COUNTER_WIDTH-1:0] r_trace_cycle;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cycle       <= '0;
            r_trace_valid <= 1'b0;
            r_trace_instr <= '0;
            r_trace_rd    <= 5'd0;
            r_trace_data  <= '0;
            r_trace_cycle <= '0;
        end else begin
            r_cycle       <= r_cycle + 1'b1;
            r_trace_valid <= retire_valid;
            if (retire_valid) begin
                r_trace_instr <= instruction_writeback;
                r_trace_rd    <= write_enable ? write_reg : 5'd0;
                r_trace_data  <= write_enable ? write_data : '0;
                r_trace_cycle <= r_cycle;
            end
        end
    end

    assign trace_valid = r_trace_valid;
    assign trace_instr = r_trace_instr;
    assign trace_rd    = r_trace_rd;
    assign trace_data  = r_trace_data;
    assign trace_cycle = r_trace_cycle;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_commit_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_commit_unit
// Description : Self-checking bench for writeback_commit_unit (default build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_commit_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ALU_result_writeback;
    logic [31:0] load_data_writeback;
    logic        opwrite_writeback;
    logic        opsel_writeback;
    logic [4:0]  opReg_writeback;
    logic [31:0] instruction_writeback;
    logic        write_enable;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        bypass_valid;
    logic [4:0]  bypass_reg;
    logic [31:0] bypass_data;
    logic        retire_valid;
    logic [63:0] instret;

    int checks = 0;
    int errors = 0;

    // Reference state: what the registered outputs must show at the next sample.
    logic        m_bv   = 1'b0;
    logic [4:0]  m_br   = 5'd0;
    logic [31:0] m_bd   = 32'd0;
    logic [63:0] m_inst = 64'd0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    writeback_commit_unit dut (
        .clock                 (clock),
        .reset                 (reset),
        .ALU_result_writeback  (ALU_result_writeback),
        .load_data_writeback   (load_data_writeback),
        .opwrite_writeback     (opwrite_writeback),
        .opsel_writeback       (opsel_writeback),
        .opReg_writeback       (opReg_writeback),
        .instruction_writeback (instruction_writeback),
        .write_enable          (write_enable),
        .write_reg             (write_reg),
        .write_data            (write_data),
        .bypass_valid          (bypass_valid),
        .bypass_reg            (bypass_reg),
        .bypass_data           (bypass_data),
        .retire_valid          (retire_valid),
        .instret               (instret)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Load result from the architectural rules: shift the addressed lane down, then extend.
    function automatic logic [31:0] model_wdata(input logic [31:0] alu, input logic [31:0] ld,
                                                input logic sel, input logic [31:0] ins);
        logic [31:0] lane;
        int          off;
        if (!sel) return alu;
        if (ins[6:0] != 7'b0000011) return ld;
        off = int'(alu[1:0]);
        case (ins[14:12])
            3'd0: begin lane = (ld >> (8 * off)) & 32'hFF;
                        return (lane >= 32'h80) ? lane - 32'h100 : lane; end
            3'd4: return (ld >> (8 * off)) & 32'hFF;
            3'd1: begin lane = (ld >> (16 * (off / 2))) & 32'hFFFF;
                        return (lane >= 32'h8000) ? lane - 32'h10000 : lane; end
            3'd5: return (ld >> (16 * (off / 2))) & 32'hFFFF;
            default: return ld;
        endcase
    endfunction

    // Compares every output against the model, then advances the model one clock.
    task automatic model_check();
        logic        e_we;
        logic        e_rv;
        logic [31:0] e_wd;
        e_we = !reset && opwrite_writeback && (opReg_writeback != 5'd0);
        e_rv = !reset && (instruction_writeback != NOP);
        e_wd = model_wdata(ALU_result_writeback, load_data_writeback,
                           opsel_writeback, instruction_writeback);
        check("write_enable", 64'(write_enable), 64'(e_we));
        check("write_reg",    64'(write_reg),    64'(opReg_writeback));
        check("write_data",   64'(write_data),   64'(e_wd));
        check("retire_valid", 64'(retire_valid), 64'(e_rv));
        check("bypass_valid", 64'(bypass_valid), 64'(m_bv));
        check("bypass_reg",   64'(bypass_reg),   64'(m_br));
        check("bypass_data",  64'(bypass_data),  64'(m_bd));
        check("instret",      instret,           m_inst);
        if (reset) begin
            m_bv = 1'b0; m_br = 5'd0; m_bd = 32'd0; m_inst = 64'd0;
        end else begin
            m_bv = e_we;
            if (e_we) begin m_br = opReg_writeback; m_bd = e_wd; end
            if (e_rv) m_inst = m_inst + 64'd1;
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] ins, input logic ow,
                         input logic os, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] ld);
        reset = r; instruction_writeback = ins; opwrite_writeback = ow;
        opsel_writeback = os; opReg_writeback = rd;
        ALU_result_writeback = alu; load_data_writeback = ld;
    endtask

    task automatic end_cycle();
        model_check();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] load_ins(input logic [2:0] f3, input logic [4:0] rd);
        return {17'd0, f3, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] addi_ins(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, rd, 7'b0010011};
    endfunction

    initial begin
        #1;
        drive(1'b1, addi_ins(5'd5, 12'd1), 1'b1, 1'b0, 5'd5, 32'h1, 32'h0);
        @(negedge clock);
        check("rst_we", 64'(write_enable), 64'd0);
        check("rst_rv", 64'(retire_valid), 64'd0);
        end_cycle();
        @(negedge clock); end_cycle();
        drive(1'b0, NOP, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clock);
        check("rst_bv", 64'(bypass_valid), 64'd0);
        check("rst_instret", instret, 64'd0);
        end_cycle();

        // Load alignment corners
        drive(1'b0, load_ins(3'b000, 5'd1), 1'b1, 1'b1, 5'd1, 32'h103, 32'h80FF_1234);
        @(negedge clock); check("lb_off3", 64'(write_data), 64'hFFFF_FF80); end_cycle();
        drive(1'b0, load_ins(3'b100, 5'd1), 1'b1, 1'b1, 5'd1, 32'h103, 32'h80FF_1234);
        @(negedge clock); check("lbu_off3", 64'(write_data), 64'h0000_0080); end_cycle();
        drive(1'b0, load_ins(3'b001, 5'd2), 1'b1, 1'b1, 5'd2, 32'h102, 32'h8001_7FFF);
        @(negedge clock); check("lh_off2", 64'(write_data), 64'hFFFF_8001); end_cycle();
        drive(1'b0, load_ins(3'b101, 5'd2), 1'b1, 1'b1, 5'd2, 32'h103, 32'h8001_7FFF);
        @(negedge clock); check("lhu_off3", 64'(write_data), 64'h0000_8001); end_cycle();

        // x0 write is suppressed but still retires
        drive(1'b0, addi_ins(5'd0, 12'd5), 1'b1, 1'b0, 5'd0, 32'h5, 32'h0);
        @(negedge clock);
        check("x0_we", 64'(write_enable), 64'd0);
        check("instret_4", instret, 64'd4);
        end_cycle();
        drive(1'b0, addi_ins(5'd7, 12'd42), 1'b1, 1'b0, 5'd7, 32'h2A, 32'h0);
        @(negedge clock);
        check("x0_bv", 64'(bypass_valid), 64'd0);
        check("instret_5", instret, 64'd5);
        end_cycle();
        drive(1'b0, NOP, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clock);
        check("byp_valid", 64'(bypass_valid), 64'd1);
        check("byp_reg", 64'(bypass_reg), 64'd7);
        check("byp_data", 64'(bypass_data), 64'h2A);
        end_cycle();
        @(negedge clock);
        check("byp_valid_clr", 64'(bypass_valid), 64'd0);
        check("byp_data_hold", 64'(bypass_data), 64'h2A);
        end_cycle();

        // 10 bubbles then 3 real instructions
        reset = 1'b1;
        @(negedge clock); end_cycle();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin @(negedge clock); end_cycle(); end
        drive(1'b0, addi_ins(5'd3, 12'd1), 1'b1, 1'b0, 5'd3, 32'h1, 32'h0);
        for (int i = 0; i < 3; i++) begin @(negedge clock); end_cycle(); end
        drive(1'b0, NOP, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clock); check("instret_3", instret, 64'd3); end_cycle();

        // Counter wrap from all-ones
        force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.r_instret;
        m_inst = 64'hFFFF_FFFF_FFFF_FFFE;
        drive(1'b0, addi_ins(5'd4, 12'd2), 1'b1, 1'b0, 5'd4, 32'h2, 32'h0);
        for (int i = 0; i < 2; i++) begin @(negedge clock); end_cycle(); end
        drive(1'b0, NOP, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clock); check("instret_wrap", instret, 64'd0); end_cycle();

        // Mid-stream reset with a live write
        drive(1'b1, addi_ins(5'd9, 12'd3), 1'b1, 1'b0, 5'd9, 32'h3, 32'h0);
        @(negedge clock);
        check("mid_rst_we", 64'(write_enable), 64'd0);
        check("mid_rst_rv", 64'(retire_valid), 64'd0);
        end_cycle();
        drive(1'b0, NOP, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clock);
        check("mid_rst_bv", 64'(bypass_valid), 64'd0);
        check("mid_rst_br", 64'(bypass_reg), 64'd0);
        check("mid_rst_bd", 64'(bypass_data), 64'd0);
        check("mid_rst_instret", instret, 64'd0);
        end_cycle();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ins;
            logic [4:0]  rd;
            ins = $urandom;
            if ($urandom_range(0, 3) == 0) ins[6:0] = 7'b0000011;
            if ($urandom_range(0, 6) == 0) ins = NOP;
            rd = 5'($urandom);
            if ($urandom_range(0, 7) == 0) rd = 5'd0;
            drive($urandom_range(0, 49) == 0, ins, 1'($urandom), 1'($urandom), rd,
                  $urandom, $urandom);
            @(negedge clock);
            end_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
